dma_streamer: RTL and testbench

- Per-direction descriptor streamer instantiated twice: STREAM_TYPE=0 for read, 1 for write.
- Sits directly downstream of the DMA control FSM. Consumes that FSM's stream valid and the active descriptor; returns the stream done pulse and stream error.
- Splits one descriptor into AXI4 INCR burst requests that never cross a 4 KB boundary and never exceed MAX_BEATS beats.
- Requests go to the AXI interface block, which owns outstanding-transaction tracking.

---
 rtl/dma_pkg.sv | 32 +++
 rtl/dma_burst_calc.sv | 28 ++
 rtl/dma_streamer.sv | 134 +++++++++++++
 tb/tb_dma_streamer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types and constants: error report, streamer states and burst request layout.
package dma_pkg;

  localparam int DMA_ADDR_W      = 32;
  localparam int AXI_4K_BOUNDARY = 4096;

  typedef logic [1:0] dma_err_src_t;

  localparam dma_err_src_t DMA_ERR_SRC_NONE = 2'd0;
  localparam dma_err_src_t DMA_ERR_SRC_RD   = 2'd1;
  localparam dma_err_src_t DMA_ERR_SRC_WR   = 2'd2;

  typedef struct packed {
    logic                  valid;
    dma_err_src_t          src;
    logic [DMA_ADDR_W-1:0] addr;
  } s_dma_error_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } dma_streamer_st_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } s_dma_burst_req_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: beats in the next burst, limited by length, 4 KB page and MAX_BEATS.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BEAT_SHIFT = 3,
  parameter int MAX_BEATS  = 256
) (
  input  logic [11:0]       addr,
  input  logic [ADDR_W-1:0] rem,
  output logic [8:0]        nb,
  output logic [7:0]        len
);

  logic [ADDR_W-1:0] beats_left_s;
  logic [8:0]        beats_cap_s;
  logic [12:0]       beats_to_4k_s;

  // Only the page offset matters for the 4 KB limit; the 13-bit domain holds 4096 itself.
  always_comb begin
    beats_left_s  = rem >> BEAT_SHIFT;
    beats_cap_s   = (beats_left_s < ADDR_W'(MAX_BEATS)) ? beats_left_s[8:0] : 9'(MAX_BEATS);
    beats_to_4k_s = (13'(AXI_4K_BOUNDARY) - {1'b0, addr}) >> BEAT_SHIFT;
    nb            = ({4'b0000, beats_cap_s} < beats_to_4k_s) ? beats_cap_s : beats_to_4k_s[8:0];
    len           = 8'(nb - 9'd1);
  end

endmodule

// File: rtl/dma_streamer.sv
// Per-direction descriptor streamer: checks alignment, then issues 4 KB-safe AXI INCR burst requests.
module dma_streamer
  import dma_pkg::*;
#(
  parameter int STREAM_TYPE = 0,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int MAX_BEATS   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_stream_valid_i,
  input  logic [ADDR_W-1:0] desc_addr_i,
  input  logic [ADDR_W-1:0] desc_num_bytes_i,
  output logic              dma_stream_done_o,
  output s_dma_error_t      dma_stream_err_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [7:0]        req_len_o,
  output logic [2:0]        req_size_o
);

  localparam int BYTES_PER_BEAT = DATA_W / 8;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

  dma_streamer_st_t  state_r, state_next_s;
  logic [ADDR_W-1:0] addr_r, rem_r;
  logic [ADDR_W-1:0] burst_bytes_s;
  logic              done_r;
  logic              req_valid_s;
  logic              align_err_s;
  logic [8:0]        nb_s;
  logic [7:0]        len_s;
  s_dma_error_t      err_s;
  s_dma_burst_req_t  req_s;

  dma_burst_calc #(
    .ADDR_W     (ADDR_W),
    .BEAT_SHIFT (BEAT_SHIFT),
    .MAX_BEATS  (MAX_BEATS)
  ) u_burst_calc (
    .addr (addr_r[11:0]),
    .rem  (rem_r),
    .nb   (nb_s),
    .len  (len_s)
  );

  assign burst_bytes_s = ADDR_W'(nb_s) << BEAT_SHIFT;
  assign align_err_s   = (addr_r[BEAT_SHIFT-1:0] != {BEAT_SHIFT{1'b0}}) ||
                         (rem_r[BEAT_SHIFT-1:0]  != {BEAT_SHIFT{1'b0}});

  // Next-state and request/error decode; payload depends only on registered state.
  always_comb begin
    state_next_s = state_r;
    req_valid_s  = 1'b0;
    err_s        = '0;
    req_s        = '0;
    req_s.size   = 3'(BEAT_SHIFT);
    case (state_r)
      ST_IDLE: begin
        if (dma_stream_valid_i) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (align_err_s) begin
          err_s.valid  = 1'b1;
          err_s.src    = (STREAM_TYPE == 0) ? DMA_ERR_SRC_RD : DMA_ERR_SRC_WR;
          err_s.addr   = DMA_ADDR_W'(addr_r);
          state_next_s = ST_DONE;
        end else if (rem_r == '0) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_REQ: begin
        req_valid_s = 1'b1;
        req_s.addr  = DMA_ADDR_W'(addr_r);
        req_s.len   = len_s;
        if (req_ready_i && (rem_r == burst_bytes_s)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_DONE: begin
        // Hold until the control FSM drops valid so a stale descriptor is not relaunched.
        if (!dma_stream_valid_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, descriptor progress and first-cycle done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      rem_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == ST_DONE) && (state_r != ST_DONE);
      if ((state_r == ST_IDLE) && dma_stream_valid_i) begin
        addr_r <= desc_addr_i;
        rem_r  <= desc_num_bytes_i;
      end else if ((state_r == ST_REQ) && req_ready_i) begin
        addr_r <= addr_r + burst_bytes_s;
        rem_r  <= rem_r - burst_bytes_s;
      end else begin
        addr_r <= addr_r;
        rem_r  <= rem_r;
      end
    end
  end

  assign dma_stream_done_o = done_r;
  assign dma_stream_err_o  = err_s;
  assign req_valid_o       = req_valid_s;
  assign req_addr_o        = ADDR_W'(req_s.addr);
  assign req_len_o         = req_s.len;
  assign req_size_o        = req_s.size;

endmodule

// File: tb/tb_dma_streamer.sv
// Directed self-checking bench: a read streamer and a write streamer driven by hand-computed vectors.
module tb_dma_streamer;
  import dma_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vld_rd = 1'b0;
  logic         vld_wr = 1'b0;
  logic [31:0]  addr = 32'h0;
  logic [31:0]  nbytes = 32'h0;
  logic         ready = 1'b1;

  logic         done_rd, done_wr;
  s_dma_error_t err_rd, err_wr;
  logic         rv_rd, rv_wr;
  logic [31:0]  ra_rd, ra_wr;
  logic [7:0]   rl_rd, rl_wr;
  logic [2:0]   rs_rd, rs_wr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_streamer #(.STREAM_TYPE(0)) dut_rd (
    .clk(clk), .rst(rst), .dma_stream_valid_i(vld_rd), .desc_addr_i(addr),
    .desc_num_bytes_i(nbytes), .dma_stream_done_o(done_rd), .dma_stream_err_o(err_rd),
    .req_valid_o(rv_rd), .req_ready_i(ready), .req_addr_o(ra_rd), .req_len_o(rl_rd),
    .req_size_o(rs_rd)
  );

  dma_streamer #(.STREAM_TYPE(1)) dut_wr (
    .clk(clk), .rst(rst), .dma_stream_valid_i(vld_wr), .desc_addr_i(addr),
    .desc_num_bytes_i(nbytes), .dma_stream_done_o(done_wr), .dma_stream_err_o(err_wr),
    .req_valid_o(rv_wr), .req_ready_i(ready), .req_addr_o(ra_wr), .req_len_o(rl_wr),
    .req_size_o(rs_wr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Read streamer outputs: request valid/addr/len, done and error valid.
  task automatic chk_rd(input string tag, input logic v, input logic [31:0] a, input logic [7:0] l,
                        input logic d);
    chk({tag, ".req_valid"}, rv_rd, v);
    chk({tag, ".req_addr"}, ra_rd, a);
    chk({tag, ".req_len"}, rl_rd, l);
    chk({tag, ".done"}, done_rd, d);
    chk({tag, ".err_valid"}, err_rd.valid, 1'b0);
  endtask

  initial begin
    cyc(); cyc();
    chk_rd("reset", 1'b0, 32'h0, 8'd0, 1'b0);
    chk("reset.size", rs_rd, 3'd3);
    rst = 1'b0;

    // 0x1000, 64 bytes: a single 8-beat burst
    addr = 32'h1000; nbytes = 32'd64; vld_rd = 1'b1;
    cyc(); chk_rd("t1.check", 1'b0, 32'h0, 8'd0, 1'b0);
    cyc(); chk_rd("t1.req", 1'b1, 32'h1000, 8'd7, 1'b0);
    cyc(); chk_rd("t1.done", 1'b0, 32'h0, 8'd0, 1'b1);
    vld_rd = 1'b0;
    cyc(); chk_rd("t1.idle", 1'b0, 32'h0, 8'd0, 1'b0);

    // 0x0FF0, 32 bytes: split at the 4 KB page, back to back
    addr = 32'h0FF0; nbytes = 32'd32; vld_rd = 1'b1;
    cyc();
    cyc(); chk_rd("t2.req0", 1'b1, 32'h0FF0, 8'd1, 1'b0);
    cyc(); chk_rd("t2.req1", 1'b1, 32'h1000, 8'd1, 1'b0);
    cyc(); chk_rd("t2.done", 1'b0, 32'h0, 8'd0, 1'b1);
    vld_rd = 1'b0;
    cyc();

    // 0x0, 4096 bytes: two MAX_BEATS bursts
    addr = 32'h0; nbytes = 32'd4096; vld_rd = 1'b1;
    cyc();
    cyc(); chk_rd("t3.req0", 1'b1, 32'h0, 8'd255, 1'b0);
    cyc(); chk_rd("t3.req1", 1'b1, 32'h800, 8'd255, 1'b0);
    cyc(); chk_rd("t3.done", 1'b0, 32'h0, 8'd0, 1'b1);
    vld_rd = 1'b0;
    cyc();

    // Misaligned write descriptor: error then done, no requests
    addr = 32'h1004; nbytes = 32'd16; vld_wr = 1'b1;
    cyc();
    chk("t4.err_valid", err_wr.valid, 1'b1);
    chk("t4.err_src", err_wr.src, DMA_ERR_SRC_WR);
    chk("t4.err_addr", err_wr.addr, 32'h1004);
    chk("t4.req_valid0", rv_wr, 1'b0);
    chk("t4.done0", done_wr, 1'b0);
    cyc();
    chk("t4.done1", done_wr, 1'b1);
    chk("t4.err_valid1", err_wr.valid, 1'b0);
    chk("t4.req_valid1", rv_wr, 1'b0);
    chk("t4.rd_idle", rv_rd, 1'b0);
    vld_wr = 1'b0;
    cyc();
    chk("t4.done2", done_wr, 1'b0);

    // Zero-length descriptor: done without any request
    addr = 32'h5000; nbytes = 32'd0; vld_rd = 1'b1;
    cyc(); chk_rd("t5.check", 1'b0, 32'h0, 8'd0, 1'b0);
    cyc(); chk_rd("t5.done", 1'b0, 32'h0, 8'd0, 1'b1);
    vld_rd = 1'b0;
    cyc();

    // Stall: payload stays constant while ready is low
    addr = 32'h2000; nbytes = 32'd16; vld_rd = 1'b1; ready = 1'b0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      cyc(); chk_rd($sformatf("t6.stall%0d", i), 1'b1, 32'h2000, 8'd1, 1'b0);
    end
    ready = 1'b1;
    cyc(); chk_rd("t6.done", 1'b0, 32'h0, 8'd0, 1'b1);
    addr = 32'h3000; nbytes = 32'd8;
    cyc(); chk_rd("t6.hold0", 1'b0, 32'h0, 8'd0, 1'b0);
    cyc(); chk_rd("t6.hold1", 1'b0, 32'h0, 8'd0, 1'b0);
    vld_rd = 1'b0;
    cyc();
    vld_rd = 1'b1;
    cyc();
    cyc(); chk_rd("t6.relaunch", 1'b1, 32'h3000, 8'd0, 1'b0);
    cyc(); chk_rd("t6.done2", 1'b0, 32'h0, 8'd0, 1'b1);
    vld_rd = 1'b0;
    cyc();

    // Reset on the second burst handshake abandons the descriptor
    addr = 32'h0FF0; nbytes = 32'd32; vld_rd = 1'b1;
    cyc();
    cyc(); chk_rd("t7.req0", 1'b1, 32'h0FF0, 8'd1, 1'b0);
    cyc(); chk_rd("t7.req1", 1'b1, 32'h1000, 8'd1, 1'b0);
    rst = 1'b1;
    cyc(); chk_rd("t7.reset", 1'b0, 32'h0, 8'd0, 1'b0);
    rst = 1'b0; vld_rd = 1'b0;
    cyc(); chk_rd("t7.idle", 1'b0, 32'h0, 8'd0, 1'b0);
    addr = 32'h4000; nbytes = 32'd8; vld_rd = 1'b1;
    cyc();
    cyc(); chk_rd("t7.restart", 1'b1, 32'h4000, 8'd0, 1'b0);
    cyc(); chk_rd("t7.done", 1'b0, 32'h0, 8'd0, 1'b1);
    vld_rd = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
